pll_cntr_reconfig_ctrl: RTL



---
 rtl/pll_cntr_reconfig_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_cntr_reconfig_ctrl.sv
// pll_cntr_reconfig_ctrl
// Scan-chain reconfiguration controller for the emulated PLL counter bank
// (M feedback, N pre-divider, C0..C(NUM_C-1) output counters). Shadow
// registers hold each counter's settings. A reconfiguration request shifts
// the whole chain out serially, pulses configupdate, then waits for scandone.
//
// Optional build macro: PLL_RECFG_READBACK_EN
//   Adds scandataout/chain_mismatch. The block keeps a copy of the last
//   successfully applied chain and compares the returned chain against it
//   bit by bit while shifting.
module pll_cntr_reconfig_ctrl #(
  parameter int NUM_C    = 5,
  parameter int CNT_BITS = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_wr,
  input  logic [3:0]          cfg_sel,
  input  logic [CNT_BITS-1:0] cfg_high,
  input  logic [CNT_BITS-1:0] cfg_low,
  input  logic                cfg_bypass,
  input  logic                cfg_odd,
  output logic                cfg_ack,
  output logic                cfg_err,
  input  logic                reconfig_start,
  output logic                busy,
  output logic                scanclkena,
  output logic                scandata,
  output logic                configupdate,
  input  logic                scandone,
  output logic                timeout_err
`ifdef PLL_RECFG_READBACK_EN
  ,
  input  logic                scandataout,
  output logic                chain_mismatch
`endif
);

  // Chain geometry: NUM_C+2 counters, each word {high, bypass, low, odd}.
  localparam int NUM_CNT = NUM_C + 2;
  localparam int WORD_W  = 2 * CNT_BITS + 2;
  localparam int TOTAL   = NUM_CNT * WORD_W;
  localparam int BIT_W   = $clog2(TOTAL);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [BIT_W-1:0]    bit_cnt;
  logic [TMO_W-1:0]    tmo_cnt;

  logic [CNT_BITS-1:0] high_sh   [NUM_CNT];
  logic [CNT_BITS-1:0] low_sh    [NUM_CNT];
  logic                bypass_sh [NUM_CNT];
  logic                odd_sh    [NUM_CNT];

  // Word i of the chain sits at bits [i*WORD_W +: WORD_W]; counter 0 (M)
  // occupies the least significant word so the MSB (shifted first) belongs
  // to the highest C counter.
  logic [TOTAL-1:0]    load_chain;
  logic [TOTAL-1:0]    shift_reg;

  logic sel_ok;
  logic wr_ok;
  logic start_ok;
  logic last_bit;
  logic tmo_hit;

  assign sel_ok   = (int'(cfg_sel) < NUM_CNT);
  assign wr_ok    = cfg_wr && (state == S_IDLE) && sel_ok;
  assign start_ok = reconfig_start && (state == S_IDLE);
  assign last_bit = (state == S_SHIFT) && (bit_cnt == BIT_W'(TOTAL - 1));
  // The timeout counter starts in UPDATE, so timeout_err becomes visible
  // exactly TIMEOUT cycles after the configupdate cycle.
  assign tmo_hit  = (state == S_WAIT) && !scandone &&
                    (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Snapshot source: current shadows with a same-cycle accepted write merged
  // in, so a write that commits on the start edge is part of the shift.
  always_comb begin
    load_chain = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (wr_ok && (int'(cfg_sel) == i))
        load_chain[i*WORD_W +: WORD_W] = {cfg_high, cfg_bypass, cfg_low, cfg_odd};
      else
        load_chain[i*WORD_W +: WORD_W] = {high_sh[i], bypass_sh[i], low_sh[i], odd_sh[i]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM next-state and state-decoded outputs.
  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    scanclkena   = 1'b0;
    scandata     = 1'b0;
    configupdate = 1'b0;
    case (state)
      S_IDLE: begin
        if (reconfig_start) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        scanclkena = 1'b1;
        scandata   = shift_reg[TOTAL-1];
        if (last_bit) state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        busy         = 1'b1;
        configupdate = 1'b1;
        state_nx     = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (scandone || tmo_hit) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bit counter for SHIFT and cycle counter for the scandone timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (start_ok)
        bit_cnt <= '0;
      else if (state == S_SHIFT)
        bit_cnt <= bit_cnt + BIT_W'(1);

      if (start_ok)
        tmo_cnt <= '0;
      else if ((state == S_UPDATE) || (state == S_WAIT))
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Host handshake pulses and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cfg_ack <= wr_ok;
      cfg_err <= cfg_wr && !wr_ok;
      if (start_ok)
        timeout_err <= 1'b0;
      else if (tmo_hit)
        timeout_err <= 1'b1;
    end
  end

  // Shadow registers; reset to high=1, low=1, no bypass, no odd correction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        high_sh[i]   <= CNT_BITS'(1);
        low_sh[i]    <= CNT_BITS'(1);
        bypass_sh[i] <= 1'b0;
        odd_sh[i]    <= 1'b0;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (int'(cfg_sel) == i) begin
          high_sh[i]   <= cfg_high;
          low_sh[i]    <= cfg_low;
          bypass_sh[i] <= cfg_bypass;
          odd_sh[i]    <= cfg_odd;
        end
      end
    end
  end

  // Chain snapshot; rotates rather than shifts so that after TOTAL cycles it
  // holds the applied chain again (used by the readback copy).
  always_ff @(posedge clk) begin
    if (start_ok)
      shift_reg <= load_chain;
    else if (state == S_SHIFT)
      shift_reg <= {shift_reg[TOTAL-2:0], shift_reg[TOTAL-1]};
  end

`ifdef PLL_RECFG_READBACK_EN
  logic [TOTAL-1:0] applied_chain;

  // Copy of the last applied chain; rotates in step with the shift so its
  // MSB is the expected readback bit for the current cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++)
        applied_chain[i*WORD_W +: WORD_W] <= {CNT_BITS'(1), 1'b0, CNT_BITS'(1), 1'b0};
      chain_mismatch <= 1'b0;
    end else begin
      if ((state == S_WAIT) && scandone)
        applied_chain <= shift_reg;
      else if (state == S_SHIFT)
        applied_chain <= {applied_chain[TOTAL-2:0], applied_chain[TOTAL-1]};

      if (start_ok)
        chain_mismatch <= 1'b0;
      else if ((state == S_SHIFT) && (scandataout != applied_chain[TOTAL-1]))
        chain_mismatch <= 1'b1;
    end
  end
`endif

endmodule
